usb_tx_encoder: RTL and testbench



---
 rtl/usb_tx_encoder.sv | 198 +++++++++++++++++++
 tb/tb_usb_tx_encoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit encoder: SYNC, LSB-first data with bit stuffing,
// NRZI line coding and EOP, paced by an internal bit-period counter.
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       dplus,
  output logic       dminus,
  output logic       tx_busy,
  output logic       tx_error
);

  localparam logic [7:0] BIT_END = 8'(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [2:0] bit_idx_reg, bit_idx_next;
  logic [7:0] data_reg, data_next;
  logic       last_reg, last_next;
  logic [2:0] ones_reg, ones_next;
  logic       level_reg, level_next;
  logic       dp_reg, dp_next;
  logic       dm_reg, dm_next;
  logic [7:0] hold_data_reg, hold_data_next;
  logic       hold_last_reg, hold_last_next;
  logic       hold_full_reg, hold_full_next;
  logic       ready_reg, ready_next;
  logic       busy_reg, busy_next;
  logic       error_reg, error_next;

  logic bit_end;
  logic load;
  logic emit_en;
  logic emit_bit;

  assign bit_end  = (cnt_reg == BIT_END);
  assign tx_ready = ready_reg;
  assign dplus    = dp_reg;
  assign dminus   = dm_reg;
  assign tx_busy  = busy_reg;
  assign tx_error = error_reg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 8'd1;
      bit_idx_reg   <= 3'd0;
      data_reg      <= 8'd0;
      last_reg      <= 1'b0;
      ones_reg      <= 3'd0;
      level_reg     <= 1'b1;
      dp_reg        <= 1'b1;
      dm_reg        <= 1'b0;
      hold_data_reg <= 8'd0;
      hold_last_reg <= 1'b0;
      hold_full_reg <= 1'b0;
      ready_reg     <= 1'b1;
      busy_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      data_reg      <= data_next;
      last_reg      <= last_next;
      ones_reg      <= ones_next;
      level_reg     <= level_next;
      dp_reg        <= dp_next;
      dm_reg        <= dm_next;
      hold_data_reg <= hold_data_next;
      hold_last_reg <= hold_last_next;
      hold_full_reg <= hold_full_next;
      ready_reg     <= ready_next;
      busy_reg      <= busy_next;
      error_reg     <= error_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_idx_next   = bit_idx_reg;
    data_next      = data_reg;
    last_next      = last_reg;
    ones_next      = ones_reg;
    level_next     = level_reg;
    dp_next        = dp_reg;
    dm_next        = dm_reg;
    hold_data_next = hold_data_reg;
    hold_last_next = hold_last_reg;
    hold_full_next = hold_full_reg;
    busy_next      = busy_reg;
    error_next     = 1'b0;
    load           = 1'b0;
    emit_en        = 1'b0;
    emit_bit       = 1'b0;

    if (state_reg == IDLE || bit_end) cnt_next = 8'd1;
    else                              cnt_next = cnt_reg + 8'd1;

    case (state_reg)
      IDLE: begin
        if (hold_full_reg) begin
          state_next   = SYNC;
          busy_next    = 1'b1;
          bit_idx_next = 3'd0;
          emit_en      = 1'b1;
        end
      end
      SYNC: begin
        if (bit_end) begin
          if (bit_idx_reg != 3'd7) begin
            bit_idx_next = bit_idx_reg + 3'd1;
            emit_en      = 1'b1;
            emit_bit     = (bit_idx_reg == 3'd6);
          end else begin
            load       = 1'b1;
            state_next = DATA;
          end
        end
      end
      DATA, STUFF: begin
        if (bit_end) begin
          // A stuff bit is owed before anything else, including the EOP.
          if (state_reg == DATA && ones_reg == 3'd6) begin
            state_next = STUFF;
            emit_en    = 1'b1;
          end else if (bit_idx_reg != 3'd7) begin
            state_next   = DATA;
            bit_idx_next = bit_idx_reg + 3'd1;
            emit_en      = 1'b1;
            emit_bit     = data_reg[bit_idx_reg + 3'd1];
          end else if (!last_reg && hold_full_reg) begin
            load       = 1'b1;
            state_next = DATA;
          end else begin
            error_next   = ~last_reg;
            state_next   = EOP_SE0;
            bit_idx_next = 3'd0;
            dp_next      = 1'b0;
            dm_next      = 1'b0;
          end
        end
      end
      EOP_SE0: begin
        if (bit_end) begin
          if (bit_idx_reg == 3'd0) begin
            bit_idx_next = 3'd1;
          end else begin
            state_next = EOP_J;
            level_next = 1'b1;
            dp_next    = 1'b1;
            dm_next    = 1'b0;
          end
        end
      end
      EOP_J: begin
        if (bit_end) begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase

    if (load) begin
      data_next      = hold_data_reg;
      last_next      = hold_last_reg;
      bit_idx_next   = 3'd0;
      hold_full_next = 1'b0;
      emit_en        = 1'b1;
      emit_bit       = hold_data_reg[0];
    end

    // NRZI: a 0 toggles the line, a 1 holds it; the ones run tracks the same bit.
    if (emit_en) begin
      level_next = emit_bit ? level_reg : ~level_reg;
      dp_next    = level_next;
      dm_next    = ~level_next;
      ones_next  = emit_bit ? ones_reg + 3'd1 : 3'd0;
    end

    if (tx_valid && !hold_full_reg) begin
      hold_full_next = 1'b1;
      hold_data_next = tx_data;
      hold_last_next = tx_last;
    end

    ready_next = ~hold_full_next;
  end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Bench for usb_tx_encoder: builds the expected per-bit line symbols from the
// packet bytes and compares the line, busy and handshake behaviour cycle by cycle.
module tb_usb_tx_encoder;

  localparam int CPB = 8;
  localparam logic [1:0] SYM_J   = 2'b10;
  localparam logic [1:0] SYM_K   = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready;
  logic       dplus;
  logic       dminus;
  logic       tx_busy;
  logic       tx_error;

  int checks = 0;
  int errors = 0;

  logic [7:0] pkt[$];
  logic [8:0] send_q[$];
  logic [1:0] exp_q[$];

  usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .dplus    (dplus),
    .dminus   (dminus),
    .tx_busy  (tx_busy),
    .tx_error (tx_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit stream -> stuffed stream -> NRZI symbols -> EOP, one symbol per bit period.
  task automatic build_model();
    bit raw[$];
    bit stf[$];
    int ones;
    bit lvl;
    exp_q.delete();
    for (int i = 0; i < 8; i++) raw.push_back(i == 7);
    foreach (pkt[k]) for (int b = 0; b < 8; b++) raw.push_back(pkt[k][b]);
    ones = 0;
    foreach (raw[i]) begin
      stf.push_back(raw[i]);
      ones = raw[i] ? ones + 1 : 0;
      if (ones == 6) begin
        stf.push_back(1'b0);
        ones = 0;
      end
    end
    lvl = 1'b1;
    foreach (stf[i]) begin
      if (!stf[i]) lvl = ~lvl;
      exp_q.push_back(lvl ? SYM_J : SYM_K);
    end
    exp_q.push_back(SYM_SE0);
    exp_q.push_back(SYM_SE0);
    exp_q.push_back(SYM_J);
  endtask

  task automatic run_packet(input string name, input bit underrun, input int abort_at);
    int   total;
    int   cyc;
    int   hs;
    int   errp;
    int   errc;
    bit   started;
    bit   done;
    logic rdy;
    build_model();
    send_q.delete();
    foreach (pkt[k]) send_q.push_back({(k == pkt.size() - 1) && !underrun, pkt[k]});
    total = exp_q.size() * CPB;
    cyc = 0; hs = 0; errp = 0; errc = -1; started = 0; done = 0; rdy = 1'b0;
    for (int t = 0; t < 4000 && !done; t++) begin
      @(negedge clk);
      if (!started) begin
        if (tx_busy) started = 1;
        else check({name, "_idle_line"}, 32'({dplus, dminus}), 32'(SYM_J));
      end
      if (started) begin
        if (tx_error) begin
          errp++;
          errc = cyc;
        end
        if (abort_at >= 0 && cyc == abort_at) begin
          n_rst = 1'b0;
          #1;
          check({name, "_rst_dplus"}, 32'(dplus), 32'd1);
          check({name, "_rst_dminus"}, 32'(dminus), 32'd0);
          check({name, "_rst_busy"}, 32'(tx_busy), 32'd0);
          check({name, "_rst_ready"}, 32'(tx_ready), 32'd1);
          check({name, "_rst_error"}, 32'(tx_error), 32'd0);
          tx_valid = 1'b0;
          send_q.delete();
          @(negedge clk);
          n_rst = 1'b1;
          done = 1;
        end else if (cyc < total) begin
          check($sformatf("%s_bit%0d_cyc%0d", name, cyc / CPB, cyc),
                32'({tx_busy, dplus, dminus}), 32'({1'b1, exp_q[cyc / CPB]}));
        end else begin
          check({name, "_end_state"}, 32'({tx_busy, dplus, dminus}), 32'({1'b0, SYM_J}));
          done = 1;
        end
        cyc++;
      end
      if (!done) begin
        if (send_q.size() > 0) begin
          tx_valid = 1'b1;
          tx_data  = send_q[0][7:0];
          tx_last  = send_q[0][8];
          rdy      = tx_ready;
        end else begin
          tx_valid = 1'b0;
          rdy      = 1'b0;
        end
        @(posedge clk);
        if (tx_valid && rdy) begin
          void'(send_q.pop_front());
          hs++;
        end
      end
    end
    tx_valid = 1'b0;
    check({name, "_completed"}, 32'(done), 32'd1);
    if (abort_at < 0) begin
      check({name, "_handshakes"}, 32'(hs), 32'(pkt.size()));
      check({name, "_error_pulses"}, 32'(errp), 32'(underrun));
      if (underrun) check({name, "_error_cycle"}, 32'(errc), 32'((exp_q.size() - 3) * CPB));
    end
    $display("pkt %s: bytes=%0d bit_periods=%0d handshakes=%0d error_pulses=%0d aborted=%0d",
             name, pkt.size(), exp_q.size(), hs, errp, abort_at >= 0);
  endtask

  initial begin
    int n;
    #1 n_rst = 1'b0;
    #1;
    check("reset_dplus", 32'(dplus), 32'd1);
    check("reset_dminus", 32'(dminus), 32'd0);
    check("reset_busy", 32'(tx_busy), 32'd0);
    check("reset_error", 32'(tx_error), 32'd0);
    check("reset_ready", 32'(tx_ready), 32'd1);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;

    pkt = {8'h00};        run_packet("single_00", 1'b0, -1);
    pkt = {8'hFF};        run_packet("single_ff", 1'b0, -1);
    pkt = {8'h3F};        run_packet("single_3f", 1'b0, -1);
    pkt = {8'hA5, 8'h3C}; run_packet("pair_a5_3c", 1'b0, -1);
    pkt = {8'h12};        run_packet("underrun_12", 1'b1, -1);
    pkt = {8'h55, 8'h77}; run_packet("reset_mid_55", 1'b0, 8 * CPB + 3 * CPB + 2);
    pkt = {8'h00};        run_packet("after_reset_00", 1'b0, -1);

    for (int p = 0; p < 8; p++) begin
      pkt.delete();
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++)
        pkt.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      repeat ($urandom_range(0, 20)) @(negedge clk);
      run_packet($sformatf("random%0d", p), 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
